mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single Avalon-MM port of mem_if between NUM_MASTERS requesters (port 0 stim reader, port 1 check writer, port 2 host/USB bridge). Uses round-robin grant with an optional lock, so multi-word transfers such as a result vector writeback land contiguously. Sits between the test-engine masters and mem_if. Every master sees a plain Avalon-MM slave with waitrequest.

## Interface
- NUM_MASTERS, 3, number of requesters (2..8)
- ADDR_WIDTH, 20, word address width
- DATA_WIDTH, 16, data width
- BE_WIDTH, DATA_WIDTH/8, byteenable width
- LOCK_MAX, 8, max consecutive transfers one master may hold under lock (≥1)
- Flattened buses: master i occupies bits [i*W +: W].

Ports:
- clock  in  1  clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clock
- m_address  in  NUM_MASTERS*ADDR_WIDTH  per-master address
- m_byteenable  in  NUM_MASTERS*BE_WIDTH  per-master byteenable
- m_read  in  NUM_MASTERS  per-master read request
- m_write  in  NUM_MASTERS  per-master write request
- m_writedata  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_lock  in  NUM_MASTERS  keep grant after current transfer
- m_readdata  out  DATA_WIDTH  read data, broadcast to all masters
- m_waitrequest  out  NUM_MASTERS  per-master stall
- mem_address  out  ADDR_WIDTH  to mem_if
- mem_byteenable  out  BE_WIDTH  to mem_if
- mem_read  out  1  to mem_if
- mem_write  out  1  to mem_if
- mem_writedata  out  DATA_WIDTH  to mem_if
- mem_readdata  in  DATA_WIDTH  from mem_if, valid when mem_read & ~mem_waitrequest
- mem_waitrequest  in  1  from mem_if
- grant  out  NUM_MASTERS  one-hot current owner (debug/status)

## Operation
- req[i] = m_read[i] | m_write[i].
- States:
  - IDLE: no owner.
  - BUSY: owner held in a registered one-hot grant.
- IDLE → BUSY when any req. Owner is the first requester at or after the priority pointer, modulo NUM_MASTERS.
- BUSY:
  - mem_* mux the owner's signals. mem_read/mem_write are forced 0 outside BUSY.
  - If the owner asserts both m_read and m_write, the write wins and mem_read = 0.
- Transfer completes on (mem_read|mem_write) & ~mem_waitrequest. On completion:
  - If m_lock[owner] = 1 and lock_cnt < LOCK_MAX-1: stay BUSY with the same owner and increment lock_cnt.
  - Otherwise: go to IDLE, clear lock_cnt, and set pointer = owner+1 (wrap to 0 past NUM_MASTERS-1).
- Owner drops req while BUSY with no transfer in flight: go to IDLE and rotate pointer as above.
- m_waitrequest[i]:
  - Equals mem_waitrequest when i is the owner in BUSY.
  - 1 otherwise, including the IDLE arbitration cycle.
- m_readdata = mem_readdata (combinational pass-through).
- lock_cnt width: clog2(LOCK_MAX)+1. A LOCK_MAX reached under continuous lock forces release; the locked master then re-arbitrates normally.

## Timing
- Reset values:
  - state IDLE, grant 0, pointer 0, lock_cnt 0.
  - mem_read 0, mem_write 0, mem_address/mem_byteenable/mem_writedata 0.
  - m_waitrequest all 1.
- Latency: request asserted in cycle n (IDLE) → grant registered at edge n+1 → mem strobe in cycle n+1. With mem_waitrequest = 0, m_waitrequest[i] = 0 in cycle n+1, so a single transfer costs 2 cycles.
- Back-to-back under lock: 1 transfer per cycle.
- Unlocked re-arbitration: 1 IDLE cycle between owners.
- The grant never changes while the owner's strobe is high and mem_waitrequest = 1.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous). The transfer is abandoned, and masters must re-issue.

## Structure
- Package mem_arb_pkg:
  - state encoding constants IDLE/BUSY.
  - master index constants MST_STIM = 0, MST_CHECK = 1, MST_HOST = 2.
  - clog2 function.
- Sub-module mem_arb_rr: combinational round-robin picker (req vector + pointer → one-hot grant + index). The top level holds the FSM, pointer, lock_cnt and muxes.

## Test plan
- Single write: master 1 writes addr 0x00010 data 0xBEEF, mem_waitrequest = 0 → mem_write high in cycle 1 with that address/data, m_waitrequest[1] = 0 in cycle 1, grant = 3'b010.
- All three request at once from reset → grants in order 0, 1, 2, each separated by one IDLE cycle. Repeat → order 0, 1, 2 again.
- Master 1 locks for 2 writes (0x0040, 0x0041) while master 0 requests → both check writes complete back-to-back before master 0 is granted.
- Continuous lock on master 2 with LOCK_MAX = 8 → forced release after 8 transfers, then master 0 is granted.
- mem_waitrequest held 1 for 5 cycles during a master 0 read → grant stable, mem_address constant, read completes on cycle 6 with m_readdata = mem_readdata.
- reset_n pulsed low mid-transfer → mem_write 0 and m_waitrequest = 3'b111 immediately, pointer 0 after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, master indices and clog2.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  localparam int unsigned MST_STIM  = 0;
  localparam int unsigned MST_CHECK = 1;
  localparam int unsigned MST_HOST  = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        res = 32'(i + 1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] cand;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = ptr_i;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
      cand = (cand == IdxW'(NumReq - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with optional lock, sharing one Avalon-MM port among several masters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned LOCK_MAX    = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]            m_read,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [DATA_WIDTH-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]            m_waitrequest,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [BE_WIDTH-1:0]               mem_byteenable,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [DATA_WIDTH-1:0]             mem_writedata,
  input  logic [DATA_WIDTH-1:0]             mem_readdata,
  input  logic                              mem_waitrequest,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int unsigned IdxW  = clog2(NUM_MASTERS);
  localparam int unsigned LockW = clog2(LOCK_MAX) + 1;

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;

  logic [NUM_MASTERS-1:0]  req;
  logic [NUM_MASTERS-1:0]  pick_gnt;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_valid;
  logic [IdxW-1:0]         ptr_next;
  logic                    busy;
  logic                    xfer_done;

  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_MASTERS];
  logic [BE_WIDTH-1:0]     be_arr   [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata_arr[NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : gen_unpack
    assign addr_arr[g]  = m_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_arr[g]    = m_byteenable[g*BE_WIDTH +: BE_WIDTH];
    assign wdata_arr[g] = m_writedata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req = m_read | m_write;

  mem_arb_rr #(
    .NumReq(NUM_MASTERS),
    .IdxW  (IdxW)
  ) u_rr (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  // Drive mem_if from the owner; strobes and buses are quiet when nobody owns the port.
  always_comb begin
    busy           = (state_q == StBusy);
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    if (busy) begin
      mem_address    = addr_arr[owner_q];
      mem_byteenable = be_arr[owner_q];
      mem_writedata  = wdata_arr[owner_q];
      mem_write      = m_write[owner_q];
      // Write wins if the owner strobes both.
      mem_read       = m_read[owner_q] & ~m_write[owner_q];
    end
    xfer_done     = (mem_read | mem_write) & ~mem_waitrequest;
    m_waitrequest = busy ? (~grant_q | {NUM_MASTERS{mem_waitrequest}}) : '1;
    m_readdata    = mem_readdata;
    grant         = grant_q;
  end

  // Next-state: arbitrate in idle, hold or release the owner in busy.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    ptr_next   = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d    = StBusy;
          grant_d    = pick_gnt;
          owner_d    = pick_idx;
          lock_cnt_d = '0;
        end
      end
      StBusy: begin
        if (xfer_done && m_lock[owner_q] && (lock_cnt_q < LockW'(LOCK_MAX - 1))) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end else if (xfer_done || !req[owner_q]) begin
          state_d    = StIdle;
          grant_d    = '0;
          lock_cnt_d = '0;
          ptr_d      = ptr_next;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (3 masters, 20-bit address, 16-bit data).
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  logic              clock;
  logic              reset_n;
  logic [N*AW-1:0]   m_address;
  logic [N*BW-1:0]   m_byteenable;
  logic [N-1:0]      m_read;
  logic [N-1:0]      m_write;
  logic [N*DW-1:0]   m_writedata;
  logic [N-1:0]      m_lock;
  logic [DW-1:0]     m_readdata;
  logic [N-1:0]      m_waitrequest;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_byteenable;
  logic              mem_read;
  logic              mem_write;
  logic [DW-1:0]     mem_writedata;
  logic [DW-1:0]     mem_readdata;
  logic              mem_waitrequest;
  logic [N-1:0]      grant;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .LOCK_MAX   (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .m_address      (m_address),
    .m_byteenable   (m_byteenable),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_lock         (m_lock),
    .m_readdata     (m_readdata),
    .m_waitrequest  (m_waitrequest),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_waitrequest(mem_waitrequest),
    .grant          (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    m_address       = '0;
    m_byteenable    = '0;
    m_read          = '0;
    m_write         = '0;
    m_writedata     = '0;
    m_lock          = '0;
    mem_readdata    = '0;
    mem_waitrequest = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with reset released.
  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    m_write = 3'b111;
    m_address = {20'h00333, 20'h00222, 20'h00111};
    #1;
    checks++;
    if (m_waitrequest !== 3'b111) begin
      errors++; $display("FAIL reset_waitreq got %b want 111", m_waitrequest);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got r%b w%b want r0 w0", mem_read, mem_write);
    end
    checks++;
    if (mem_address !== 20'h0 || grant !== 3'b000) begin
      errors++; $display("FAIL reset_addr_grant got %h/%b want 00000/000", mem_address, grant);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_write();
    apply_reset();
    m_write[1] = 1'b1;
    m_address[1*AW +: AW] = 20'h00010;
    m_writedata[1*DW +: DW] = 16'hBEEF;
    m_byteenable[1*BW +: BW] = 2'b11;
    @(negedge clock);
    checks++;
    if (mem_write !== 1'b0 || m_waitrequest !== 3'b111) begin
      errors++; $display("FAIL single_c0 got w%b wr%b want w0 wr111", mem_write, m_waitrequest);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 20'h00010 || mem_writedata !== 16'hBEEF) begin
      errors++; $display("FAIL single_c1_bus got w%b a%h d%h want w1 a00010 dBEEF",
                         mem_write, mem_address, mem_writedata);
    end
    checks++;
    if (m_waitrequest !== 3'b101 || grant !== 3'b010 || mem_byteenable !== 2'b11) begin
      errors++; $display("FAIL single_c1_ctl got wr%b g%b be%b want wr101 g010 be11",
                         m_waitrequest, grant, mem_byteenable);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    checks++;
    if (grant !== 3'b000 || mem_write !== 1'b0) begin
      errors++; $display("FAIL single_c2 got g%b w%b want g000 w0", grant, mem_write);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [12];
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
              3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    apply_reset();
    m_read = 3'b111;
    m_address = {20'h00102, 20'h00101, 20'h00100};
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      checks++;
      if (grant !== exp_g[c] || mem_read !== (exp_g[c] != 3'b000)) begin
        errors++; $display("FAIL rr_cycle%0d got g%b r%b want g%b r%b", c, grant, mem_read,
                           exp_g[c], (exp_g[c] != 3'b000));
      end
      if (exp_g[c] == 3'b010) begin
        checks++;
        if (mem_address !== 20'h00101) begin
          errors++; $display("FAIL rr_addr%0d got %h want 00101", c, mem_address);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_lock_pair();
    apply_reset();
    m_write[1] = 1'b1;
    m_lock[1] = 1'b1;
    m_address[1*AW +: AW] = 20'h00040;
    m_writedata[1*DW +: DW] = 16'h1111;
    @(negedge clock);
    next_cycle();
    m_read[0] = 1'b1;
    m_address[0*AW +: AW] = 20'h00005;
    @(negedge clock);
    checks++;
    if (grant !== 3'b010 || mem_write !== 1'b1 || mem_address !== 20'h00040) begin
      errors++; $display("FAIL lock_w1 got g%b w%b a%h want g010 w1 a00040",
                         grant, mem_write, mem_address);
    end
    next_cycle();
    m_lock[1] = 1'b0;
    m_address[1*AW +: AW] = 20'h00041;
    m_writedata[1*DW +: DW] = 16'h2222;
    @(negedge clock);
    checks++;
    if (grant !== 3'b010 || mem_address !== 20'h00041 || mem_writedata !== 16'h2222) begin
      errors++; $display("FAIL lock_w2 got g%b a%h d%h want g010 a00041 d2222",
                         grant, mem_address, mem_writedata);
    end
    next_cycle();
    m_write[1] = 1'b0;
    @(negedge clock);
    checks++;
    if (grant !== 3'b000 || m_waitrequest !== 3'b111) begin
      errors++; $display("FAIL lock_idle got g%b wr%b want g000 wr111", grant, m_waitrequest);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (grant !== 3'b001 || mem_read !== 1'b1 || mem_address !== 20'h00005) begin
      errors++; $display("FAIL lock_m0 got g%b r%b a%h want g001 r1 a00005",
                         grant, mem_read, mem_address);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_lock_max();
    apply_reset();
    m_write[2] = 1'b1;
    m_lock[2] = 1'b1;
    m_address[2*AW +: AW] = 20'h00200;
    @(negedge clock);
    for (int t = 1; t <= 8; t++) begin
      next_cycle();
      if (t == 1) begin
        m_read[0] = 1'b1;
      end
      m_writedata[2*DW +: DW] = 16'(t);
      @(negedge clock);
      checks++;
      if (grant !== 3'b100 || mem_write !== 1'b1) begin
        errors++; $display("FAIL lockmax_t%0d got g%b w%b want g100 w1", t, grant, mem_write);
      end
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (grant !== 3'b000) begin
      errors++; $display("FAIL lockmax_release got g%b want g000", grant);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (grant !== 3'b001 || mem_read !== 1'b1) begin
      errors++; $display("FAIL lockmax_m0 got g%b r%b want g001 r1", grant, mem_read);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_waitrequest();
    apply_reset();
    mem_waitrequest = 1'b1;
    mem_readdata = 16'hA5C3;
    m_read[0] = 1'b1;
    m_address[0*AW +: AW] = 20'h12345;
    @(negedge clock);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      @(negedge clock);
      checks++;
      if (grant !== 3'b001 || mem_read !== 1'b1 || mem_address !== 20'h12345 ||
          m_waitrequest !== 3'b111) begin
        errors++; $display("FAIL wait_c%0d got g%b r%b a%h wr%b want g001 r1 a12345 wr111",
                           c, grant, mem_read, mem_address, m_waitrequest);
      end
    end
    next_cycle();
    mem_waitrequest = 1'b0;
    @(negedge clock);
    checks++;
    if (m_waitrequest !== 3'b110 || m_readdata !== 16'hA5C3 || grant !== 3'b001) begin
      errors++; $display("FAIL wait_done got wr%b rd%h g%b want wr110 rdA5C3 g001",
                         m_waitrequest, m_readdata, grant);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_write[0] = 1'b1;
    next_cycle();
    next_cycle();
    m_write = 3'b010;
    m_address[1*AW +: AW] = 20'h00777;
    mem_waitrequest = 1'b1;
    next_cycle();
    @(negedge clock);
    checks++;
    if (grant !== 3'b010 || mem_write !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got g%b w%b want g010 w1", grant, mem_write);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || m_waitrequest !== 3'b111 || grant !== 3'b000 ||
        mem_address !== 20'h0) begin
      errors++; $display("FAIL rstmid_async got w%b wr%b g%b a%h want w0 wr111 g000 a00000",
                         mem_write, m_waitrequest, grant, mem_address);
    end
    next_cycle();
    reset_n = 1'b1;
    mem_waitrequest = 1'b0;
    m_write = 3'b011;
    @(negedge clock);
    next_cycle();
    @(negedge clock);
    checks++;
    if (grant !== 3'b001) begin
      errors++; $display("FAIL rstmid_ptr got g%b want g001", grant);
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock_pair();
    test_lock_max();
    test_waitrequest();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
